// File: rtl/ureg_cell.sv
// ureg_cell: universal shift/rotate register with single-step and counted multi-step operation.
// Define UREG_ROTATE_EN to enable the rotate modes (100/101); otherwise they behave as hold.
module ureg_cell #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] notq,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_q, w_q_nx, w_sq;
  logic             r_sout, w_sout_nx, w_ss;
  logic             r_done, w_done_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [2:0]       r_mode, w_mode_nx, w_op;
  logic             w_multi;
  assign w_op = (r_state == RUN) ? r_mode : mode;
`ifdef UREG_ROTATE_EN
  assign w_multi = (w_op[2:1] == 2'b01) || (w_op[2:1] == 2'b10);
`else
  assign w_multi = (w_op[2:1] == 2'b01);
`endif
  // one step of the selected operation applied to the current contents
  always_comb begin
    w_sq = r_q;
    w_ss = r_sout;
    case (w_op)
      3'b001: w_sq = d;
      3'b010: {w_ss, w_sq} = {r_q, sin};
      3'b011: {w_sq, w_ss} = {sin, r_q};
`ifdef UREG_ROTATE_EN
      3'b100: begin
        w_sq = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_ss = r_q[WIDTH-1];
      end
      3'b101: begin
        w_sq = {r_q[0], r_q[WIDTH-1:1]};
        w_ss = r_q[0];
      end
`endif
      3'b110: w_sq = '0;
      3'b111: w_sq = '1;
      default: ;
    endcase
  end
  always_comb begin
    w_state_nx = r_state;
    w_q_nx     = r_q;
    w_sout_nx  = r_sout;
    w_cnt_nx   = r_cnt;
    w_mode_nx  = r_mode;
    w_done_nx  = 1'b0;
    if (r_state == RUN) begin
      w_q_nx    = w_sq;
      w_sout_nx = w_ss;
      w_cnt_nx  = r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        w_state_nx = IDLE;
        w_done_nx  = 1'b1;
      end
    end else if (start) begin
      w_mode_nx = mode;
      w_done_nx = 1'b1;
      if (amt != '0) begin
        w_q_nx    = w_sq;
        w_sout_nx = w_ss;
      end
      // r_cnt holds the steps still to come after the start edge
      if (w_multi && amt > CNT_W'(1)) begin
        w_state_nx = RUN;
        w_cnt_nx   = amt - 1'b1;
        w_done_nx  = 1'b0;
      end
    end else if (en) begin
      w_q_nx    = w_sq;
      w_sout_nx = w_ss;
    end
  end
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_mode  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_q     <= w_q_nx;
      r_sout  <= w_sout_nx;
      r_done  <= w_done_nx;
      r_cnt   <= w_cnt_nx;
      r_mode  <= w_mode_nx;
    end
  end
  assign q    = r_q;
  assign notq = ~r_q;
  assign sout = r_sout;
  assign busy = (r_state == RUN);
  assign done = r_done;
endmodule

// File: doc/ureg_cell.md
UREG_CELL -- requirements
Module: ureg_cell

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, 4, register width in bits (>=2).
REQ-002 Parameter CNT_W SHALL be: CNT_W, 2, width of the multi-step shift amount.
REQ-003 Port SHALL be: clk  input  1  single clock; all state changes on posedge.
REQ-004 Port SHALL be: r_n  input  1  asynchronous, active-low reset.
REQ-005 Port SHALL be: en  input  1  single-step operation enable.
REQ-006 Port SHALL be: mode  input  3  operation select.
REQ-007 Port SHALL be: d  input  WIDTH  parallel load data.
REQ-008 Port SHALL be: sin  input  1  serial input for shift modes.
REQ-009 Port SHALL be: start  input  1  begin multi-step operation.
REQ-010 Port SHALL be: amt  input  CNT_W  number of steps for start.
REQ-011 Port SHALL be: q  output  WIDTH  register contents.
REQ-012 Port SHALL be: notq  output  WIDTH  bitwise inverse of q, combinational.
REQ-013 Port SHALL be: sout  output  1  bit shifted or rotated out by the most recent step, registered.
REQ-014 Port SHALL be: busy  output  1  multi-step operation has steps remaining.
REQ-015 Port SHALL be: done  output  1  one-cycle completion pulse.

Function
REQ-016 Mode encoding SHALL be: 000 hold, 001 load q<=d, 010 shl (LSB<=sin, sout<=old MSB), 011 shr (MSB<=sin, sout<=old LSB), 100 rotl, 101 rotr, 110 clear q<=0, 111 set q<=all ones.
REQ-017 Rotate modes SHALL set sout to the bit that wrapped around; hold, load, clear and set SHALL leave sout unchanged.
REQ-018 In IDLE with start=0 and en=1, exactly one step of mode SHALL be applied at the next edge; en=0 SHALL hold q.
REQ-019 start=1 in IDLE SHALL take priority over en, and SHALL latch mode and amt.
REQ-020 For start with a shift/rotate mode and amt=N>0, one step SHALL be applied at each of the N edges beginning with the start edge; the sin value present at each edge SHALL be used.
REQ-021 busy SHALL be high after each of the first N-1 step edges, so it never asserts for N=1; state SHALL be RUN while busy=1 and IDLE otherwise.
REQ-022 done SHALL be high for exactly one cycle, after the edge that performs the last step.
REQ-023 For start with amt=0, q SHALL be unchanged and done SHALL pulse after the start edge.
REQ-024 For start with modes 000/001/110/111, that operation SHALL be applied once and done SHALL pulse after the start edge.
REQ-025 While busy=1, en, start, mode, amt and d SHALL be ignored.
REQ-026 A new start SHALL be accepted in the same cycle that done is high.

Reset
REQ-027 r_n low SHALL immediately force q=0, sout=0, busy=0, done=0, step counter=0 and state IDLE, independent of clk.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first edge after r_n rises SHALL behave as IDLE.

Configuration
REQ-029 With macro UREG_ROTATE_EN defined, modes 100/101 SHALL rotate as specified.
REQ-030 Without UREG_ROTATE_EN, modes 100/101 SHALL behave as hold: q and sout are unchanged, and start with these modes pulses done after the start edge with busy never asserted.

Verification (WIDTH=4, CNT_W=2)
REQ-031 Scenario: r_n low with no clock edge -> q=0000, notq=1111, busy=0, done=0, sout=0 immediately.
REQ-032 Scenario: en=1, mode=001, d=1011 -> q=1011 after one edge, done=0.
REQ-033 Scenario: q=1011, start, mode=010, amt=3, sin=0 -> q=0110, 1100, 1000 on successive edges; busy high for 2 cycles; done high one cycle after the third edge; sout=1.
REQ-034 Scenario: during REQ-033 busy, en=1, mode=001, d=1111 -> ignored; final q=1000.
REQ-035 Scenario: q=0001, start, mode=101, amt=1 -> with UREG_ROTATE_EN q=1000, sout=1, done pulse, busy never high; without the macro q=0001 and done pulses.
REQ-036 Scenario: start shl with amt=3, then r_n low after the first step -> q=0000, busy=0, done=0 at once; no done pulse after release.
